// File: rtl/equation_parser.sv
// Streaming checker for statements of the form EXPR '=' EXPR ';'.
// Phases: EXPECT = waiting for an operand or '(' | AFTER = an operand/')' just closed | ERROR = sticky until ';'.
module equation_parser #(
  parameter int MAX_DEPTH  = 7,
  parameter int MULTI_CHAR = 1,
  parameter int SKIP_SPACE = 1,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     in,
  input  logic                           in_valid,
  output logic                           out,
  output logic                           err,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic [CNT_W-1:0]               eq_count,
  output logic [CNT_W-1:0]               err_count
);

  localparam int DW = $clog2(MAX_DEPTH + 1);

  typedef enum logic [1:0] {EXPECT, AFTER, ERROR} phase_e;

  phase_e            phase_q, phase_d;
  logic              side_q, side_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              last_opnd_q, last_opnd_d;
  logic              started_q, started_d;
  logic [CNT_W-1:0]  eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic is_opnd, is_op, is_lp, is_rp, is_eq, is_term, is_sp;

  always_comb begin
    is_opnd = ((in >= 8'h61) && (in <= 8'h7a)) || ((in >= 8'h41) && (in <= 8'h5a)) ||
              ((in >= 8'h30) && (in <= 8'h39));
    is_op   = (in == 8'h2b) || (in == 8'h2d) || (in == 8'h2a) || (in == 8'h2f);
    is_lp   = (in == 8'h28);
    is_rp   = (in == 8'h29);
    is_eq   = (in == 8'h3d);
    is_term = (in == 8'h3b);
    is_sp   = (in == 8'h20);
  end

  always_comb begin
    phase_d     = phase_q;
    side_d      = side_q;
    depth_d     = depth_q;
    last_opnd_d = last_opnd_q;
    started_d   = started_q;
    eq_cnt_d    = eq_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (in_valid) begin
      if (is_term) begin
        if (phase_q == AFTER && side_q && depth_q == '0) begin
          if (eq_cnt_q != {CNT_W{1'b1}}) eq_cnt_d = eq_cnt_q + 1'b1;
        end else if (started_q) begin
          if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
        phase_d     = EXPECT;
        side_d      = 1'b0;
        depth_d     = '0;
        last_opnd_d = 1'b0;
        started_d   = 1'b0;
      end else if (phase_q != ERROR) begin
        if (is_sp) begin
          // A skipped space still splits operands, so "ab c" cannot merge.
          if (SKIP_SPACE != 0) last_opnd_d = 1'b0;
          else                 phase_d     = ERROR;
        end else begin
          started_d = 1'b1;
          phase_d   = ERROR;
          if (phase_q == EXPECT) begin
            if (is_opnd) begin
              phase_d     = AFTER;
              last_opnd_d = 1'b1;
            end else if (is_lp && depth_q != DW'(MAX_DEPTH)) begin
              phase_d = EXPECT;
              depth_d = depth_q + 1'b1;
            end
          end else begin
            if (is_opnd && MULTI_CHAR != 0 && last_opnd_q) begin
              phase_d = AFTER;
            end else if (is_op) begin
              phase_d     = EXPECT;
              last_opnd_d = 1'b0;
            end else if (is_rp && depth_q != '0) begin
              phase_d     = AFTER;
              depth_d     = depth_q - 1'b1;
              last_opnd_d = 1'b0;
            end else if (is_eq && !side_q && depth_q == '0) begin
              phase_d     = EXPECT;
              side_d      = 1'b1;
              last_opnd_d = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= EXPECT;
      side_q      <= 1'b0;
      depth_q     <= '0;
      last_opnd_q <= 1'b0;
      started_q   <= 1'b0;
      eq_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      side_q      <= side_d;
      depth_q     <= depth_d;
      last_opnd_q <= last_opnd_d;
      started_q   <= started_d;
      eq_cnt_q    <= eq_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out       = (phase_q == AFTER) && side_q && (depth_q == '0);
  assign err       = (phase_q == ERROR);
  assign depth     = depth_q;
  assign eq_count  = eq_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_equation_parser.sv
// Directed bench for equation_parser: default instance driven from a vector table,
// plus parameter-variant instances exercised by short hand-written sequences.
module tb_equation_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in = 8'h00;
  logic       in_valid = 1'b0;

  logic       out_a, err_a;
  logic [2:0] depth_a;
  logic [7:0] eqc_a, errc_a;

  logic       out_b, err_b;
  logic [1:0] depth_b;
  logic [1:0] eqc_b, errc_b;

  logic       out_c, err_c;
  logic [2:0] depth_c;
  logic [7:0] eqc_c, errc_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  equation_parser dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .out(out_a), .err(err_a), .depth(depth_a), .eq_count(eqc_a), .err_count(errc_a));

  equation_parser #(.MAX_DEPTH(2), .CNT_W(2)) dut_d2 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .out(out_b), .err(err_b), .depth(depth_b), .eq_count(eqc_b), .err_count(errc_b));

  equation_parser #(.MULTI_CHAR(0), .SKIP_SPACE(0)) dut_mc0 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .out(out_c), .err(err_c), .depth(depth_c), .eq_count(eqc_c), .err_count(errc_c));

  typedef struct {
    byte        ch;
    logic       e_out;
    logic       e_err;
    logic [2:0] e_depth;
    logic [7:0] e_eq;
    logic [7:0] e_errc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input byte ch);
    @(negedge clk);
    in = ch;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out", {31'd0, out_a | out_b | out_c}, 32'd0);
    chk("rst_err", {31'd0, err_a | err_b | err_c}, 32'd0);
    chk("rst_depth", {29'd0, depth_a | {1'b0, depth_b} | depth_c}, 32'd0);
    chk("rst_cnt", {24'd0, eqc_a | errc_a | eqc_c | errc_c | {6'd0, eqc_b | errc_b}}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic void add(input string s, input logic o, input logic e,
                              input logic [2:0] d, input logic [7:0] q, input logic [7:0] r);
    for (int i = 0; i < s.len(); i++) begin
      vec_t v;
      v.ch = s[i]; v.e_out = o; v.e_err = e; v.e_depth = d; v.e_eq = q; v.e_errc = r;
      vecs.push_back(v);
    end
  endfunction

  initial begin
    add("a+b=", 0, 0, 0, 0, 0); add("c", 1, 0, 0, 0, 0); add(";", 0, 0, 0, 1, 0);
    add("(x*", 0, 0, 1, 1, 0); add("(y-2", 0, 0, 2, 1, 0); add(")", 0, 0, 1, 1, 0);
    add(")=", 0, 0, 0, 1, 0); add("z9", 1, 0, 0, 1, 0); add(";", 0, 0, 0, 2, 0);
    add("a=", 0, 0, 0, 2, 0); add("b", 1, 0, 0, 2, 0); add("=c", 0, 1, 0, 2, 0);
    add(";", 0, 0, 0, 2, 1);
    add(";;", 0, 0, 0, 2, 1);
    add("a + b = ", 0, 0, 0, 2, 1); add("c", 1, 0, 0, 2, 1); add(";", 0, 0, 0, 3, 1);
    add("ab ", 0, 0, 0, 3, 1); add("c", 0, 1, 0, 3, 1); add(";", 0, 0, 0, 3, 2);
    add("3*", 0, 0, 0, 3, 2); add("(a", 0, 0, 1, 3, 2); add(";", 0, 0, 0, 3, 3);
    add("a", 0, 0, 0, 3, 3); add(")=b", 0, 1, 0, 3, 3); add(";", 0, 0, 0, 3, 4);
    add("a=", 0, 0, 0, 3, 4); add("b", 1, 0, 0, 3, 4); add("#c", 0, 1, 0, 3, 4);
    add(";", 0, 0, 0, 3, 5);

    do_reset();

    foreach (vecs[i]) begin
      send(vecs[i].ch);
      chk($sformatf("v%0d_out", i), {31'd0, out_a}, {31'd0, vecs[i].e_out});
      chk($sformatf("v%0d_err", i), {31'd0, err_a}, {31'd0, vecs[i].e_err});
      chk($sformatf("v%0d_depth", i), {29'd0, depth_a}, {29'd0, vecs[i].e_depth});
      chk($sformatf("v%0d_eqc", i), {24'd0, eqc_a}, {24'd0, vecs[i].e_eq});
      chk($sformatf("v%0d_errc", i), {24'd0, errc_a}, {24'd0, vecs[i].e_errc});
    end

    // in_valid low must freeze everything, even with a terminator on the bus
    send("a");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in = ";"; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_err", {31'd0, err_a}, 32'd0);
      chk("hold_eqc", {24'd0, eqc_a}, 32'd3);
    end
    send_str("=q");
    chk("hold_out_before", {31'd0, out_a}, 32'd1);
    @(negedge clk); in = ";"; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_out", {31'd0, out_a}, 32'd1);
    chk("hold_eqc2", {24'd0, eqc_a}, 32'd3);
    send(";");
    chk("hold_eqc3", {24'd0, eqc_a}, 32'd4);

    // nesting limit of 2
    do_reset();
    send_str("((");
    chk("d2_depth", {30'd0, depth_b}, 32'd2);
    chk("d2_err_pre", {31'd0, err_b}, 32'd0);
    send("(");
    chk("d2_err", {31'd0, err_b}, 32'd1);
    send("a");
    chk("d2_err_sticky", {31'd0, err_b}, 32'd1);
    send(";");
    chk("d2_err_clr", {31'd0, err_b}, 32'd0);
    chk("d2_errc", {30'd0, errc_b}, 32'd1);
    chk("d2_depth0", {30'd0, depth_b}, 32'd0);

    // single-char operands, spaces illegal
    do_reset();
    send("a");
    chk("mc0_a", {31'd0, err_c}, 32'd0);
    send("b");
    chk("mc0_b", {31'd0, err_c}, 32'd1);
    send_str("=c;");
    chk("mc0_errc", {24'd0, errc_c}, 32'd1);
    chk("mc0_eqc", {24'd0, eqc_c}, 32'd0);
    send_str("a=b");
    chk("mc0_out", {31'd0, out_c}, 32'd1);
    send(" ");
    chk("mc0_sp", {31'd0, err_c}, 32'd1);
    send(";");
    chk("mc0_errc2", {24'd0, errc_c}, 32'd2);

    // asynchronous reset mid-statement discards it
    send_str("a+b=c");
    chk("ar_out_pre", {31'd0, out_a}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out", {31'd0, out_a}, 32'd0);
    chk("ar_eqc", {24'd0, eqc_a}, 32'd0);
    chk("ar_errc", {24'd0, errc_a}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    send_str("x=y;");
    chk("ar_after_eqc", {24'd0, eqc_a}, 32'd1);
    chk("ar_after_errc", {24'd0, errc_a}, 32'd0);

    // 2-bit counter saturation
    do_reset();
    for (int k = 0; k < 3; k++) send_str("a=b;");
    chk("sat_3", {30'd0, eqc_b}, 32'd3);
    for (int k = 0; k < 2; k++) send_str("a=b;");
    chk("sat_5", {30'd0, eqc_b}, 32'd3);
    chk("sat_eqc_wide", {24'd0, eqc_a}, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
